// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store bridge to data_memory with fault detection.
// Optional: define MISALIGN_TRAP_EN to fault misaligned LH/LHU/LW/SH/SW.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic        mem_byte,
    input  logic [31:0] mem_read_data
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] STORE_HI = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    logic [1:0]  state;
    logic        l_store;
    logic [2:0]  l_funct3;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic [32:0] size;
    logic [32:0] last;
    logic        bad_op;
    logic        out_of_range;
    logic        misalign;
    logic        fault;
    logic        is_sh;
    logic        byte_op;
    logic [31:0] ext;

    always_comb begin
        unique case (req_funct3[1:0])
            2'b00:   size = 33'd1;
            2'b01:   size = 33'd2;
            default: size = 33'd4;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign last         = {1'b0, req_addr} + size - 33'd1;
    assign out_of_range = last >= 33'(MEM_BYTES);

    assign bad_op = req_store
        ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
        : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);

`ifdef MISALIGN_TRAP_EN
    assign misalign =
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) ||
        (req_funct3[1:0] == 2'b01 && req_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    assign fault   = bad_op || out_of_range || misalign;
    assign is_sh   = l_store && l_funct3[1:0] == 2'b01;
    assign byte_op = l_funct3[1:0] == 2'b00 || is_sh;

    always_comb begin
        unique case (l_funct3)
            3'b000:  ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b100:  ext = {24'b0, mem_read_data[7:0]};
            3'b001:  ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b101:  ext = {16'b0, mem_read_data[15:0]};
            default: ext = mem_read_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            l_store    <= 1'b0;
            l_funct3   <= 3'b0;
            l_addr     <= 32'b0;
            l_wdata    <= 32'b0;
            resp_rdata <= 32'b0;
            resp_fault <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_store  <= req_store;
                        l_funct3 <= req_funct3;
                        l_addr   <= req_addr;
                        l_wdata  <= req_wdata;
                        if (fault) begin
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'b0;
                            state      <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    resp_fault <= 1'b0;
                    resp_rdata <= l_store ? 32'b0 : ext;
                    state      <= is_sh ? STORE_HI : RESP;
                end
                STORE_HI: state <= RESP;
                default:  state <= IDLE;
            endcase
        end
    end

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;

    always_comb begin
        mem_address    = 32'b0;
        mem_write_data = 32'b0;
        mem_MemRead    = 1'b0;
        mem_MemWrite   = 1'b0;
        mem_byte       = 1'b0;
        unique case (1'b1)
            state == ACCESS: begin
                mem_address  = l_addr;
                mem_byte     = byte_op;
                mem_MemRead  = !l_store;
                mem_MemWrite = l_store;
                if (l_store)
                    mem_write_data = is_sh ? {24'b0, l_wdata[7:0]} : l_wdata;
            end
            state == STORE_HI: begin
                mem_address    = l_addr + 32'd1;
                mem_byte       = 1'b1;
                mem_MemWrite   = 1'b1;
                mem_write_data = {24'b0, l_wdata[15:8]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random checks of load_store_unit against a
// byte-array reference model, with a behavioural data_memory attached.
module tb_load_store_unit;
    localparam int MB = 1024;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
    localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic        mem_byte;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_BYTES(MB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_byte(mem_byte), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    bit [7:0] mem [MB];
    bit [7:0] ref_mem [MB];
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [31:0] wl_addr [$];
    logic [31:0] wl_data [$];
    bit          wl_byte [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] rdb(input logic [31:0] a);
        return (a < MB) ? mem[a[9:0]] : 8'h00;
    endfunction

    // behavioural data_memory: combinational read, clocked write
    always_comb begin
        if (mem_byte)
            mem_read_data = {24'b0, rdb(mem_address)};
        else
            mem_read_data = {rdb(mem_address + 3), rdb(mem_address + 2),
                             rdb(mem_address + 1), rdb(mem_address)};
    end

    always @(posedge clk) begin
        if (!reset && mem_MemRead) rd_cnt <= rd_cnt + 1;
        if (!reset && mem_MemWrite) begin
            wr_cnt <= wr_cnt + 1;
            wl_addr.push_back(mem_address);
            wl_data.push_back(mem_write_data);
            wl_byte.push_back(mem_byte);
            for (int i = 0; i < (mem_byte ? 1 : 4); i++)
                if (mem_address + i < MB)
                    mem[10'(mem_address + i)] <= mem_write_data[8*i +: 8];
        end
    end

    always @(negedge clk) begin
        if (!reset && (req_ready || resp_valid))
            chk("idle_strobes", {27'b0, mem_MemRead, mem_MemWrite, mem_byte,
                |mem_address, |mem_write_data}, 32'b0);
    end

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00: return 1;
            2'b01: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_fault(input bit st, input logic [2:0] f3,
                                       input logic [31:0] a);
        longint last;
        int sz;
        bit legal;
        sz = size_of(f3);
        legal = st ? (f3 inside {F_B, F_H, F_W})
                   : (f3 inside {F_B, F_H, F_W, F_BU, F_HU});
        last = longint'(a) + sz - 1;
        if (!legal || last >= MB) return 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (a % sz != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < size_of(f3); i++)
            v[8*i +: 8] = ref_mem[10'(a + i)];
        case (f3)
            F_B: if (v[7]) v = v | 32'hFFFF_FF00;
            F_H: if (v[15]) v = v | 32'hFFFF_0000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic run(input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] r);
        bit flt;
        int lat, lat_exp, wr0, rd0, wexp, rexp;
        logic [31:0] exp_rd;
        flt = model_fault(st, f3, a);
        exp_rd = (!flt && !st) ? model_load(f3, a) : 32'b0;
        lat_exp = flt ? 1 : (st && f3 == F_H) ? 3 : 2;
        wexp = (flt || !st) ? 0 : (f3 == F_H ? 2 : 1);
        rexp = (!flt && !st) ? 1 : 0;
        chk("ready", req_ready, 1);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        req_valid = 1; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; req_store = 1'($urandom);
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, lat_exp);
        chk("fault", resp_fault, flt);
        chk("rdata", resp_rdata, exp_rd);
        chk("writes", wr_cnt - wr0, wexp);
        chk("reads", rd_cnt - rd0, rexp);
        r = resp_rdata;
        if (!flt && st)
            for (int i = 0; i < size_of(f3); i++)
                ref_mem[10'(a + i)] = wd[8*i +: 8];
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r, a;
        int n0, diff, sel;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_fault", resp_fault, 0);
        chk("rst_mem", {mem_MemRead, mem_MemWrite, mem_byte}, 0);
        reset = 0;
        @(posedge clk); #1;

        n0 = wl_addr.size();
        run(1, F_W, 32'h10, 32'hDEADBEEF, r);
        chk("sw_nwr", wl_addr.size() - n0, 1);
        chk("sw_byte", wl_byte[n0], 0);
        chk("sw_addr", wl_addr[n0], 32'h10);
        chk("sw_data", wl_data[n0], 32'hDEADBEEF);
        run(0, F_W, 32'h10, 0, r);   chk("lw10", r, 32'hDEADBEEF);
        run(0, F_B, 32'h13, 0, r);   chk("lb13", r, 32'hFFFFFFDE);
        run(0, F_BU, 32'h13, 0, r);  chk("lbu13", r, 32'h000000DE);
        run(0, F_B, 32'h10, 0, r);   chk("lb10", r, 32'hFFFFFFEF);

        n0 = wl_addr.size();
        run(1, F_H, 32'h20, 32'h1234ABCD, r);
        chk("sh_lo_addr", wl_addr[n0], 32'h20);
        chk("sh_lo_data", {24'b0, wl_data[n0][7:0]}, 32'hCD);
        chk("sh_lo_byte", wl_byte[n0], 1);
        chk("sh_hi_addr", wl_addr[n0+1], 32'h21);
        chk("sh_hi_data", wl_data[n0+1], 32'hAB);
        chk("sh_hi_byte", wl_byte[n0+1], 1);
        run(0, F_HU, 32'h20, 0, r);  chk("lhu20", r, 32'h0000ABCD);
        run(0, F_H, 32'h20, 0, r);   chk("lh20", r, 32'hFFFFABCD);

        run(0, 3'b011, 32'h0, 0, r);
        run(1, 3'b100, 32'h0, 32'h55, r);
        run(0, F_W, 32'h3FE, 0, r);
        run(0, F_W, 32'h3FC, 0, r);
        run(0, F_W, 32'hFFFF_FFFF, 0, r);
        run(0, F_W, 32'h11, 0, r);
`ifdef MISALIGN_TRAP_EN
        chk("lw11_trap", resp_fault, 1);
`else
        chk("lw11", r, {ref_mem[10'h14], 24'hDEADBE});
`endif

        run(1, F_B, 32'h22, 32'h5A, r);
        req_valid = 1; req_store = 1; req_funct3 = F_H;
        req_addr = 32'h21; req_wdata = 32'h000077C3;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
`ifdef MISALIGN_TRAP_EN
        chk("sh21_trap_we", mem_MemWrite, 0);
`else
        chk("sh21_hi_we", mem_MemWrite, 1);
        chk("sh21_hi_addr", mem_address, 32'h22);
        chk("sh21_hi_data", mem_write_data, 32'h77);
        ref_mem[10'h21] = 8'hC3;
`endif
        reset = 1;
        #1;
        chk("rstmid_we", mem_MemWrite, 0);
        chk("rstmid_ready", req_ready, 1);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rstmid_valid", resp_valid, 0);
        end
        reset = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_valid", resp_valid, 0);
        end
        chk("byte22_kept", mem[10'h22], 32'h5A);
        chk("byte21", mem[10'h21], ref_mem[10'h21]);

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) a = $urandom_range(0, MB - 1);
            else if (sel < 9) a = $urandom_range(MB - 8, MB + 7);
            else a = $urandom;
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                a, $urandom, r);
        end

        diff = 0;
        for (int i = 0; i < MB; i++)
            if (mem[i] != ref_mem[i]) diff++;
        chk("mem_image", diff, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bridges the execute stage and `data_memory`. It accepts one RV32 load/store request per handshake and decodes funct3 into the memory's byte/word strobes. Halfword stores are split into two sequential byte writes. Load data is sign- or zero-extended, and illegal or out-of-range accesses are reported as faults without touching memory.

## Interface
Parameters:
- `MEM_BYTES`, default 1024: size of the attached byte memory. Accesses ending at or beyond it fault.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and faults
- `resp_fault`  out  1  access rejected
- `mem_address`  out  32  to `data_memory.address`
- `mem_write_data`  out  32  to `data_memory.write_data`
- `mem_MemRead`, `mem_MemWrite`, `mem_byte`  out  1 each  to the matching `data_memory` inputs
- `mem_read_data`  in  32  from `data_memory.read_data` (combinational)

## Operation
- States: IDLE, ACCESS, STORE_HI, RESP. `req_ready` = (state == IDLE).
- Acceptance:
  - IDLE with `req_valid` latches store, funct3, addr and wdata.
  - Legal request → ACCESS. Fault → RESP directly.
- Fault conditions:
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
  - `addr + size − 1 >= MEM_BYTES`, where size is 1/2/4 bytes.
- ACCESS:
  - `mem_address` = latched addr.
  - `mem_byte` = 1 for LB/LBU/SB/SH, 0 for LH/LHU/LW/SW.
  - Loads: `mem_MemRead`=1; `mem_read_data` is captured at the end of the cycle. Then → RESP.
  - SB/SW: `mem_MemWrite`=1, `mem_write_data` = wdata. Then → RESP.
  - SH: writes byte wdata[7:0] at addr. Then → STORE_HI.
- STORE_HI: `mem_MemWrite`=1, `mem_byte`=1, `mem_address` = addr+1, `mem_write_data` = {24'b0, wdata[15:8]}. Then → RESP.
- Load extension:
  - LB: sign-extend bit 7. LBU: zero-extend [7:0].
  - LH: sign-extend bit 15 of the word read. LHU: zero-extend [15:0].
  - LW: unchanged.
- RESP: `resp_valid`=1, `resp_fault` as computed. Then → IDLE.
- `resp_rdata`/`resp_fault` are registered and hold until the next RESP.
- All `mem_*` outputs are 0 in IDLE and RESP; a fault never asserts any memory strobe.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Request accepted at edge N (IDLE, `req_valid`=1).
- Load, SB, SW: ACCESS in cycle N+1, `resp_valid` in cycle N+2.
- SH: ACCESS in cycle N+1, STORE_HI in cycle N+2, `resp_valid` in cycle N+3.
- Fault: `resp_valid` in cycle N+1.
- `req_ready` returns to 1 in the cycle after RESP, so peak throughput is one request per 3 cycles.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, all `mem_*`=0.
- Reset asserted mid-operation:
  - Strobes drop immediately and the response is discarded.
  - A write already clocked at an earlier edge stays in memory; no further write occurs, including the SH high byte.
- Address arithmetic is 32-bit; addr+1 wraps modulo 2^32. The range check compares with 33-bit precision.

## Configuration
- `MISALIGN_TRAP_EN` defined: LW/SW with addr[1:0]≠0, and LH/LHU/SH with addr[0]≠0, fault with no memory access, `resp_valid` at N+1.
- Not defined: misaligned accesses proceed byte-granular; only the range check applies.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `resp_rdata`=0xDEADBEEF at N+2; one `mem_MemWrite` pulse with `mem_byte`=0.
- After that store, LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LB @0x10 → 0xFFFFFFEF.
- SH 0x1234ABCD @0x20 → byte write (0x20, 0xCD) at N+1 and (0x21, 0xAB) at N+2, `resp_valid` at N+3; LHU @0x20 → 0x0000ABCD; LH @0x20 → 0xFFFFABCD.
- Load funct3=011 → `resp_fault`=1 at N+1, no `mem_MemRead`; LW @0x3FE with MEM_BYTES=1024 → fault; LW @0x3FC → succeeds.
- LW @0x11 after the test-1 store → with `MISALIGN_TRAP_EN`: fault, no access. Without: `resp_rdata` = {mem[0x14], 0xDE, 0xAD, 0xBE}.
- Assert `reset` during STORE_HI of SH @0x21 → `mem_MemWrite` drops immediately; byte 0x22 unchanged; `req_ready`=1; no `resp_valid`.
